id_stage_pipe: RTL and testbench

//  Parametrised RV32I decode stage with registered ID/EX boundary. Decodes fields, reads the integer register file, and generates the immediate.

---
 rtl/id_pkg.sv | 38 +++
 rtl/imm_decode.sv | 31 +++
 rtl/id_stage_pipe.sv | 135 +++++++++++++
 tb/tb_id_stage_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared RV32I decode definitions: base opcodes, immediate formats and the
// opcode-to-format mapping used by the ID stage.
package id_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    t = IMM_NONE;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: t = IMM_I;
      OP_STORE:                 t = IMM_S;
      OP_BRANCH:                t = IMM_B;
      OP_LUI, OP_AUIPC:         t = IMM_U;
      OP_JAL:                   t = IMM_J;
      default:                  t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I immediate generator; every format is sign-extended
// from instr[31] to XLEN bits.
module imm_decode
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  imm_type_e imm_type;
  logic      sign;

  assign imm_type = imm_type_of(instr[6:0]);
  assign sign     = instr[31];

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{(XLEN-12){sign}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){sign}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-12){sign}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      // instr[31] is folded into the replication so XLEN=32 never needs a zero-width repeat
      IMM_U: imm = {{(XLEN-31){sign}}, instr[30:12], 12'b0};
      IMM_J: imm = {{(XLEN-20){sign}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage: register file, immediate generation, load-use bubble
// insertion and the registered ID/EX boundary. Define ID_WB_BYPASS_EN to make
// register reads see a same-cycle WB write.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] PC_ID,
  input  logic [31:0]     INSTRUCTION_ID,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            RegWrite_WB,
  input  logic [RA_W-1:0] RD_WB,
  input  logic [XLEN-1:0] ALU_DATA_WB,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [RA_W-1:0] ex_rd,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic            ex_mem_read,
  output logic [31:0]     hazard_cnt
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RA_W-1:0] rd, rs1, rs2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            uses_rs1, uses_rs2;
  logic            hazard, advance;
  logic            wb_write;

  assign opcode = INSTRUCTION_ID[6:0];
  assign rd     = INSTRUCTION_ID[7+:RA_W];
  assign funct3 = INSTRUCTION_ID[14:12];
  assign rs1    = INSTRUCTION_ID[15+:RA_W];
  assign rs2    = INSTRUCTION_ID[20+:RA_W];
  assign funct7 = INSTRUCTION_ID[31:25];

  imm_decode #(.XLEN(XLEN)) u_imm (
    .instr (INSTRUCTION_ID),
    .imm   (imm)
  );

  // Register file: x0 has no storage, entries 1..NUM_REGS-1 are flops so they clear on reset.
  logic [XLEN-1:0] regs [1:NUM_REGS-1];

  assign wb_write = RegWrite_WB && (RD_WB != '0);

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_rf
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        regs[gi] <= '0;
      else if (wb_write && (RD_WB == RA_W'(gi)))
        regs[gi] <= ALU_DATA_WB;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != '0) rs1_data = regs[rs1];
    if (rs2 != '0) rs2_data = regs[rs2];
`ifdef ID_WB_BYPASS_EN
    if (wb_write && (RD_WB == rs1)) rs1_data = ALU_DATA_WB;
    if (wb_write && (RD_WB == rs2)) rs2_data = ALU_DATA_WB;
`endif
  end

  always_comb begin
    uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    uses_rs2 = (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  end

  assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                  ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));

  assign advance  = ex_ready || !ex_valid;
  assign id_ready = flush || (advance && !hazard);

  // ID/EX register; flush beats stall beats bubble beats a normal load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7   <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_mem_read <= 1'b0;
      hazard_cnt  <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (!advance) begin
      ex_valid <= ex_valid;
    end else if (hazard) begin
      ex_valid <= 1'b0;
      if (hazard_cnt != '1)
        hazard_cnt <= hazard_cnt + 32'd1;
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= PC_ID;
      ex_imm      <= imm;
      ex_rs1_data <= rs1_data;
      ex_rs2_data <= rs2_data;
      ex_opcode   <= opcode;
      ex_funct3   <= funct3;
      ex_funct7   <= funct7;
      ex_rd       <= rd;
      ex_rs1      <= rs1;
      ex_rs2      <= rs2;
      ex_mem_read <= (opcode == OP_LOAD);
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a 32-bit and a 64-bit instance share stimulus.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        flush;
  logic        ex_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        id_ready;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [6:0]  ex_opcode, ex_funct7;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_mem_read;
  logic [31:0] hazard_cnt;

  logic        id_ready64, ex_valid64, ex_mem_read64;
  logic [63:0] ex_pc64, ex_imm64, ex_rs1_data64, ex_rs2_data64;
  logic [6:0]  ex_opcode64, ex_funct764;
  logic [2:0]  ex_funct364;
  logic [4:0]  ex_rd64, ex_rs164, ex_rs264;
  logic [31:0] hazard_cnt64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .PC_ID(pc), .INSTRUCTION_ID(instr), .flush(flush), .ex_ready(ex_ready),
    .RegWrite_WB(wb_en), .RD_WB(wb_rd), .ALU_DATA_WB(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_mem_read(ex_mem_read), .hazard_cnt(hazard_cnt)
  );

  id_stage_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready64),
    .PC_ID({32'h0, pc}), .INSTRUCTION_ID(instr), .flush(flush), .ex_ready(ex_ready),
    .RegWrite_WB(wb_en), .RD_WB(wb_rd), .ALU_DATA_WB({32'h0, wb_data}),
    .ex_valid(ex_valid64), .ex_pc(ex_pc64), .ex_imm(ex_imm64),
    .ex_rs1_data(ex_rs1_data64), .ex_rs2_data(ex_rs2_data64),
    .ex_opcode(ex_opcode64), .ex_funct3(ex_funct364), .ex_funct7(ex_funct764),
    .ex_rd(ex_rd64), .ex_rs1(ex_rs164), .ex_rs2(ex_rs264),
    .ex_mem_read(ex_mem_read64), .hazard_cnt(hazard_cnt64)
  );

  localparam logic [31:0] I_ADDI_X6_X5_1  = 32'h00128313;
  localparam logic [31:0] I_ADDI_X6_X0_1  = 32'h00100313;
  localparam logic [31:0] I_ADDI_X4_X3_0  = 32'h00018213;
  localparam logic [31:0] I_LW_X7_X1      = 32'h0000A383;
  localparam logic [31:0] I_LW_X0_X1      = 32'h0000A003;
  localparam logic [31:0] I_LW_X10_X7     = 32'h0003A503;
  localparam logic [31:0] I_ADD_X8_X7_X2  = 32'h00238433;
  localparam logic [31:0] I_ADD_X8_X9_X2  = 32'h00248433;
  localparam logic [31:0] I_ADD_X8_X0_X2  = 32'h00200433;
  localparam logic [31:0] I_ADD_X11_X10_X2 = 32'h002505B3;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] ins);
    id_valid = v;
    pc       = p;
    instr    = ins;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_valid = 1'b0; pc = '0; instr = '0; flush = 1'b0;
    ex_ready = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    tick(); tick();
    checks++;
    if (ex_valid !== 1'b0 || hazard_cnt !== 32'd0 || ex_pc !== 32'd0 || ex_imm !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: ex_valid=%b hazard_cnt=%0d ex_pc=%h ex_imm=%h, required 0/0/0/0",
               ex_valid, hazard_cnt, ex_pc, ex_imm);
    end
    rst_n = 1'b1;
    tick();
    $display("reset: ex_valid=%b hazard_cnt=%0d", ex_valid, hazard_cnt);
  endtask

  task automatic test_write_read();
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    wb_en = 1'b0;
    drive(1'b1, 32'h100, I_ADDI_X6_X5_1);
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1_data !== 32'hDEADBEEF || ex_imm !== 32'd1 ||
        ex_rd !== 5'd6 || ex_rs1 !== 5'd5 || ex_opcode !== 7'h13 || ex_pc !== 32'h100) begin
      errors++;
      $display("FAIL write_read: valid=%b rs1_data=%h imm=%h rd=%0d rs1=%0d op=%h pc=%h, required 1/deadbeef/1/6/5/13/100",
               ex_valid, ex_rs1_data, ex_imm, ex_rd, ex_rs1, ex_opcode, ex_pc);
    end
    $display("write_read: addi x6,x5,1 rs1_data=%h imm=%h", ex_rs1_data, ex_imm);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    wb_en = 1'b0;
    drive(1'b1, 32'h104, I_ADDI_X6_X0_1);
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1_data !== 32'd0) begin
      errors++;
      $display("FAIL x0_write: valid=%b rs1_data=%h, required 1/00000000", ex_valid, ex_rs1_data);
    end
    $display("x0_write: rs1_data=%h", ex_rs1_data);
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h200, I_LW_X7_X1);
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1 || ex_rd !== 5'd7) begin
      errors++;
      $display("FAIL lw_issue: valid=%b mem_read=%b rd=%0d, required 1/1/7", ex_valid, ex_mem_read, ex_rd);
    end
    drive(1'b1, 32'h204, I_ADD_X8_X7_X2);
    #1;
    checks++;
    if (id_ready !== 1'b0) begin
      errors++;
      $display("FAIL lu_stall_ready: id_ready=%b, required 0", id_ready);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || hazard_cnt !== 32'd1 || id_ready !== 1'b1) begin
      errors++;
      $display("FAIL lu_bubble: ex_valid=%b hazard_cnt=%0d id_ready=%b, required 0/1/1", ex_valid, hazard_cnt, id_ready);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd8 || ex_rs1 !== 5'd7 || ex_mem_read !== 1'b0 || ex_pc !== 32'h204) begin
      errors++;
      $display("FAIL lu_add_issue: valid=%b rd=%0d rs1=%0d mem_read=%b pc=%h, required 1/8/7/0/204",
               ex_valid, ex_rd, ex_rs1, ex_mem_read, ex_pc);
    end
    $display("load_use: bubble inserted, hazard_cnt=%0d", hazard_cnt);

    // rd=x0 load and an unrelated consumer must not stall
    drive(1'b1, 32'h210, I_LW_X0_X1);
    tick();
    drive(1'b1, 32'h214, I_ADD_X8_X0_X2);
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL lu_x0_ready: id_ready=%b, required 1", id_ready);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h214 || hazard_cnt !== 32'd1) begin
      errors++;
      $display("FAIL lu_x0_issue: valid=%b pc=%h hazard_cnt=%0d, required 1/214/1", ex_valid, ex_pc, hazard_cnt);
    end
    drive(1'b1, 32'h220, I_LW_X7_X1);
    tick();
    drive(1'b1, 32'h224, I_ADD_X8_X9_X2);
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL lu_nodep_ready: id_ready=%b, required 1", id_ready);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h224 || hazard_cnt !== 32'd1) begin
      errors++;
      $display("FAIL lu_nodep_issue: valid=%b pc=%h hazard_cnt=%0d, required 1/224/1", ex_valid, ex_pc, hazard_cnt);
    end
    $display("load_use: no bubble for rd=x0 and independent add");
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h300, I_LW_X7_X1);
    tick();
    drive(1'b1, 32'h304, I_ADD_X8_X7_X2);
    flush = 1'b1;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: id_ready=%b, required 1", id_ready);
    end
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if (ex_valid !== 1'b0 || hazard_cnt !== 32'd1) begin
      errors++;
      $display("FAIL flush_kill: ex_valid=%b hazard_cnt=%0d, required 0/1", ex_valid, hazard_cnt);
    end
    $display("flush: ex_valid=%b hazard_cnt=%0d", ex_valid, hazard_cnt);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h400, I_LW_X7_X1);
    tick();
    drive(1'b1, 32'h404, I_LW_X10_X7);
    tick();
    checks++;
    if (ex_valid !== 1'b0 || hazard_cnt !== 32'd2) begin
      errors++;
      $display("FAIL b2b_bubble1: ex_valid=%b hazard_cnt=%0d, required 0/2", ex_valid, hazard_cnt);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h404 || ex_mem_read !== 1'b1) begin
      errors++;
      $display("FAIL b2b_lw2_issue: valid=%b pc=%h mem_read=%b, required 1/404/1", ex_valid, ex_pc, ex_mem_read);
    end
    drive(1'b1, 32'h408, I_ADD_X11_X10_X2);
    tick();
    checks++;
    if (ex_valid !== 1'b0 || hazard_cnt !== 32'd3) begin
      errors++;
      $display("FAIL b2b_bubble2: ex_valid=%b hazard_cnt=%0d, required 0/3", ex_valid, hazard_cnt);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h408 || ex_rd !== 5'd11) begin
      errors++;
      $display("FAIL b2b_add_issue: valid=%b pc=%h rd=%0d, required 1/408/11", ex_valid, ex_pc, ex_rd);
    end
    $display("back_to_back: hazard_cnt=%0d", hazard_cnt);
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h500, I_ADDI_X6_X5_1);
    tick();
    ex_ready = 1'b0;
    drive(1'b1, 32'h504, I_ADDI_X4_X3_0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (id_ready !== 1'b0 || ex_valid !== 1'b1 || ex_pc !== 32'h500 || ex_rd !== 5'd6 ||
          ex_rs1_data !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL backpressure_hold%0d: id_ready=%b valid=%b pc=%h rd=%0d rs1_data=%h, required 0/1/500/6/deadbeef",
                 i, id_ready, ex_valid, ex_pc, ex_rd, ex_rs1_data);
      end
      tick();
    end
    ex_ready = 1'b1;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h504 || ex_rd !== 5'd4) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b pc=%h rd=%0d, required 1/504/4", ex_valid, ex_pc, ex_rd);
    end
    $display("backpressure: released, ex_pc=%h", ex_pc);
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    wb_data = 32'h55;
    drive(1'b1, 32'h600, I_ADDI_X4_X3_0);
    tick();
    wb_en = 1'b0;
`ifdef ID_WB_BYPASS_EN
    exp = 32'h55;
`else
    exp = 32'h11;
`endif
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1_data !== exp) begin
      errors++;
      $display("FAIL bypass: valid=%b rs1_data=%h, required 1/%h", ex_valid, ex_rs1_data, exp);
    end
    $display("bypass: x3 read as %h", ex_rs1_data);
  endtask

  task automatic test_immediates();
    logic [31:0] ins [9];
    logic [31:0] e32 [9];
    logic [63:0] e64 [9];
    ins[0] = 32'hFE000EE3; e32[0] = 32'hFFFFFFFC; e64[0] = 64'hFFFFFFFFFFFFFFFC; // beq -4
    ins[1] = 32'h123450B7; e32[1] = 32'h12345000; e64[1] = 64'h0000000012345000; // lui
    ins[2] = 32'h800000B7; e32[2] = 32'h80000000; e64[2] = 64'hFFFFFFFF80000000; // lui negative
    ins[3] = 32'h004000EF; e32[3] = 32'h00000004; e64[3] = 64'h0000000000000004; // jal +4
    ins[4] = 32'hFF9FF06F; e32[4] = 32'hFFFFFFF8; e64[4] = 64'hFFFFFFFFFFFFFFF8; // jal -8
    ins[5] = 32'hFE20AE23; e32[5] = 32'hFFFFFFFC; e64[5] = 64'hFFFFFFFFFFFFFFFC; // sw -4
    ins[6] = 32'h0020A423; e32[6] = 32'h00000008; e64[6] = 64'h0000000000000008; // sw +8
    ins[7] = 32'hFFF00093; e32[7] = 32'hFFFFFFFF; e64[7] = 64'hFFFFFFFFFFFFFFFF; // addi -1
    ins[8] = 32'h00238433; e32[8] = 32'h00000000; e64[8] = 64'h0000000000000000; // add: no imm
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h700 + 32'(i * 4), ins[i]);
      tick();
      checks++;
      if (ex_valid !== 1'b1 || ex_imm !== e32[i] || ex_valid64 !== 1'b1 || ex_imm64 !== e64[i]) begin
        errors++;
        $display("FAIL imm_%0d: instr=%h imm32=%h imm64=%h, required %h / %h",
                 i, ins[i], ex_imm, ex_imm64, e32[i], e64[i]);
      end
      $display("imm: instr=%h imm32=%h imm64=%h", ins[i], ex_imm, ex_imm64);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 32'h800, I_ADDI_X6_X5_1);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || hazard_cnt !== 32'd0 || ex_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: ex_valid=%b hazard_cnt=%0d ex_pc=%h, required 0/0/0", ex_valid, hazard_cnt, ex_pc);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h804, I_ADDI_X6_X5_1);
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1_data !== 32'd0 || ex_pc !== 32'h804) begin
      errors++;
      $display("FAIL reset_x5_cleared: valid=%b rs1_data=%h pc=%h, required 1/0/804", ex_valid, ex_rs1_data, ex_pc);
    end
    $display("reset_midstream: x5 reads %h", ex_rs1_data);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_backpressure();
    test_bypass();
    test_immediates();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
